// File: rtl/axi2mem_tcdm_wr_unit_if.sv
// Bundle of all non-clock signals of axi2mem_tcdm_wr_unit.
// Groups: per-lane command stream, beat data stream, write-response request, two TCDM write ports.
// slave = the wr unit's view (accepts cmd/data, drives TCDM); master = the upstream/TCDM environment.
interface axi2mem_tcdm_wr_unit_if #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32
);
    // per-lane command stream from the write-channel front-end
    logic [1:0]                 trans_req_i;
    logic [1:0][ID_WIDTH-1:0]   trans_id_i;
    logic [1:0][ADDR_WIDTH-1:0] trans_add_i;
    logic [1:0]                 trans_last_i;
    logic [1:0]                 trans_gnt_o;

    // 64-bit beat data, split into two 32-bit lanes
    logic                       data_req_i;
    logic [63:0]                data_dat_i;
    logic [7:0]                 data_strb_i;
    logic                       data_gnt_o;

    // write-response request back to the front-end
    logic                       trans_r_req_o;
    logic [ID_WIDTH-1:0]        trans_r_id_o;
    logic                       trans_r_gnt_i;

    // two TCDM write master ports
    logic [1:0]                 tcdm_req_o;
    logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o;
    logic [1:0]                 tcdm_wen_o;
    logic [1:0][31:0]           tcdm_wdata_o;
    logic [1:0][3:0]            tcdm_be_o;
    logic [1:0]                 tcdm_gnt_i;

    modport slave (
        input  trans_req_i, trans_id_i, trans_add_i, trans_last_i,
        output trans_gnt_o,
        input  data_req_i, data_dat_i, data_strb_i,
        output data_gnt_o,
        output trans_r_req_o, trans_r_id_o,
        input  trans_r_gnt_i,
        output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        input  tcdm_gnt_i
    );

    modport master (
        output trans_req_i, trans_id_i, trans_add_i, trans_last_i,
        input  trans_gnt_o,
        output data_req_i, data_dat_i, data_strb_i,
        input  data_gnt_o,
        input  trans_r_req_o, trans_r_id_o,
        output trans_r_gnt_i,
        input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        output tcdm_gnt_i
    );
endinterface

// File: rtl/axi2mem_tcdm_wr_unit.sv
// Purpose: buffers the dual-lane AXI write command/data stream and issues it as two 32-bit TCDM write
//          ports; after the last beat retires on both lanes, requests a B response with the burst ID.
// Latency: push at edge N -> tcdm_req in N+1; last grant on later lane at M -> trans_r_req in M+1.
// Backpressure: trans_gnt_o/data_gnt_o are FIFO-not-full from registered state only; a lane that
//          finished its burst stalls until the response is accepted.
// Ports: clk_i, rst_ni (async, active low), bus (axi2mem_tcdm_wr_unit_if.slave).
// Optional feature macro: AXI2MEM_WR_SKIP_NULL_STRB_EN -- beats with an all-zero lane byte enable
//          are retired locally without a TCDM request.

// Small generic FIFO: registered storage, head read straight from storage (no fall-through).
module axi2mem_tcdm_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Requests against a full/empty FIFO are ignored so the pointers can never cross.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // DEPTH is a power of two, so the natural pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is reset so the TCDM address/data outputs read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= dat_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dat_o   = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

module axi2mem_tcdm_wr_unit #(
    parameter int CMD_DEPTH  = 4,
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    axi2mem_tcdm_wr_unit_if.slave bus
);
    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] add;
        logic                  last;
    } cmd_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } wdat_t;

    typedef enum logic {L_RUN, L_DONE} lane_state_e;
    typedef enum logic {R_IDLE, R_RESP} resp_state_e;

    // FIFO plumbing
    cmd_t        cmd_in   [2];
    cmd_t        cmd_head [2];
    wdat_t       dat_in   [2];
    wdat_t       dat_head [2];
    logic [1:0]  cmd_push;
    logic [1:0]  cmd_full, cmd_empty;
    logic [1:0]  dat_full, dat_empty;
    logic        data_push;

    // lane control
    lane_state_e         lane_q [2];
    lane_state_e         lane_d [2];
    logic [ID_WIDTH-1:0] id_q   [2];
    logic [ID_WIDTH-1:0] id_d   [2];
    logic [1:0]          head_vld;
    logic [1:0]          null_be;
    logic [1:0]          pop;

    // response control
    resp_state_e resp_q, resp_d;
    logic        resp_hs;

    // TCDM output staging
    logic [1:0]                 tcdm_req;
    logic [1:0][ADDR_WIDTH-1:0] tcdm_add;
    logic [1:0][31:0]           tcdm_wdata;
    logic [1:0][3:0]            tcdm_be;

    // Both data lanes are pushed together, so one grant covers both halves of a beat.
    assign bus.data_gnt_o = ~dat_full[0] & ~dat_full[1];
    assign data_push      = bus.data_req_i & bus.data_gnt_o;
    assign bus.trans_gnt_o = ~cmd_full;

    assign resp_hs = (resp_q == R_RESP) & bus.trans_r_gnt_i;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cmd_in[k].id    = bus.trans_id_i[k];
            cmd_in[k].add   = bus.trans_add_i[k];
            cmd_in[k].last  = bus.trans_last_i[k];
            dat_in[k].wdata = bus.data_dat_i[32*k +: 32];
            dat_in[k].be    = bus.data_strb_i[4*k +: 4];
            cmd_push[k]     = bus.trans_req_i[k] & ~cmd_full[k];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        axi2mem_tcdm_wr_fifo #(
            .WIDTH ($bits(cmd_t)),
            .DEPTH (CMD_DEPTH)
        ) i_cmd_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (cmd_push[g]),
            .dat_i   (cmd_in[g]),
            .pop_i   (pop[g]),
            .dat_o   (cmd_head[g]),
            .full_o  (cmd_full[g]),
            .empty_o (cmd_empty[g])
        );

        axi2mem_tcdm_wr_fifo #(
            .WIDTH ($bits(wdat_t)),
            .DEPTH (CMD_DEPTH)
        ) i_dat_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (data_push),
            .dat_i   (dat_in[g]),
            .pop_i   (pop[g]),
            .dat_o   (dat_head[g]),
            .full_o  (dat_full[g]),
            .empty_o (dat_empty[g])
        );
    end

    // Lane FSMs: issue a beat when both the command and its data are at the FIFO heads.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lane_d[k]   = lane_q[k];
            id_d[k]     = id_q[k];
            tcdm_req[k] = 1'b0;
            pop[k]      = 1'b0;
            head_vld[k] = ~cmd_empty[k] & ~dat_empty[k];
`ifdef AXI2MEM_WR_SKIP_NULL_STRB_EN
            null_be[k]  = (dat_head[k].be == 4'b0000);
`else
            null_be[k]  = 1'b0;
`endif
            tcdm_add[k]   = cmd_head[k].add;
            tcdm_wdata[k] = dat_head[k].wdata;
            tcdm_be[k]    = dat_head[k].be;

            if ((lane_q[k] == L_RUN) && head_vld[k]) begin
                // A null-strobe beat retires locally in one cycle, as if granted.
                tcdm_req[k] = ~null_be[k];
                pop[k]      = null_be[k] | bus.tcdm_gnt_i[k];
            end

            if (pop[k] && cmd_head[k].last) begin
                lane_d[k] = L_DONE;
                id_d[k]   = cmd_head[k].id;
            end

            // Only reachable from L_DONE: both lanes are parked while the response is pending.
            if (resp_hs) lane_d[k] = L_RUN;
        end
    end

    // Response FSM looks at the lanes' next state so the request rises the cycle after the
    // later lane's last grant rather than one cycle later.
    always_comb begin
        resp_d = resp_q;
        case (resp_q)
            R_IDLE: if ((lane_d[0] == L_DONE) && (lane_d[1] == L_DONE)) resp_d = R_RESP;
            R_RESP: if (bus.trans_r_gnt_i) resp_d = R_IDLE;
            default: resp_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q <= R_IDLE;
            for (int k = 0; k < 2; k++) begin
                lane_q[k] <= L_RUN;
                id_q[k]   <= '0;
            end
        end else begin
            resp_q <= resp_d;
            for (int k = 0; k < 2; k++) begin
                lane_q[k] <= lane_d[k];
                id_q[k]   <= id_d[k];
            end
        end
    end

    // Both lanes carry the same burst ID; lane 0's copy is the one reported.
    assign bus.trans_r_req_o = (resp_q == R_RESP);
    assign bus.trans_r_id_o  = id_q[0];

    assign bus.tcdm_req_o   = tcdm_req;
    assign bus.tcdm_add_o   = tcdm_add;
    assign bus.tcdm_wdata_o = tcdm_wdata;
    assign bus.tcdm_be_o    = tcdm_be;
    assign bus.tcdm_wen_o   = 2'b00;
endmodule

// File: tb/tb_axi2mem_tcdm_wr_unit.sv
// Self-checking bench for axi2mem_tcdm_wr_unit: table of single-beat bursts with hand-computed lane
// splits, plus directed multi-cycle sequences, with a scoreboard of expected TCDM writes and response IDs.
// Inputs are driven 1 time unit after the rising edge; the scoreboard samples handshakes on the falling edge.
module tb_axi2mem_tcdm_wr_unit;
    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    axi2mem_tcdm_wr_unit_if #(.ID_WIDTH(6), .ADDR_WIDTH(32)) bus ();

    axi2mem_tcdm_wr_unit #(
        .CMD_DEPTH  (4),
        .ID_WIDTH   (6),
        .ADDR_WIDTH (32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] add;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    typedef struct {
        logic [5:0]  id;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [63:0] dat;
        logic [7:0]  strb;
        logic [31:0] e_wd0;
        logic [31:0] e_wd1;
        logic [3:0]  e_be0;
        logic [3:0]  e_be1;
    } vec_t;

    beat_t      exp_beats0[$];
    beat_t      exp_beats1[$];
    logic [5:0] exp_ids[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired, required event did not occur", name);
    endfunction

    function automatic bit lane_issues(input logic [3:0] be);
`ifdef AXI2MEM_WR_SKIP_NULL_STRB_EN
        return (be != 4'b0000);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void sb_beat(input int k);
        beat_t e;
        bit    have;
        have = (k == 0) ? (exp_beats0.size() != 0) : (exp_beats1.size() != 0);
        if (!have) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_lane%0d_unexpected: got write to 0x%0h, required none", k, bus.tcdm_add_o[k]);
            return;
        end
        if (k == 0) e = exp_beats0.pop_front();
        else        e = exp_beats1.pop_front();
        check($sformatf("sb_lane%0d_add", k),   bus.tcdm_add_o[k],   e.add);
        check($sformatf("sb_lane%0d_wdata", k), bus.tcdm_wdata_o[k], e.wdata);
        check($sformatf("sb_lane%0d_be", k),    bus.tcdm_be_o[k],    e.be);
        check($sformatf("sb_lane%0d_wen", k),   bus.tcdm_wen_o[k],   1'b0);
    endfunction

    // Scoreboard: TCDM writes and response IDs consumed on their handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tcdm_req_o[0] && bus.tcdm_gnt_i[0]) sb_beat(0);
            if (bus.tcdm_req_o[1] && bus.tcdm_gnt_i[1]) sb_beat(1);
            if (bus.trans_r_req_o && bus.trans_r_gnt_i) begin
                if (exp_ids.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_resp_unexpected: got id 0x%0h, required no response", bus.trans_r_id_o);
                end else begin
                    check("sb_resp_id", bus.trans_r_id_o, exp_ids.pop_front());
                end
            end
        end
    end

    task automatic push_beat(input logic [5:0] id, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [1:0] last, input logic [63:0] d, input logic [7:0] s);
        int    w;
        beat_t b;
        w = 0;
        while (!(bus.trans_gnt_o == 2'b11 && bus.data_gnt_o) && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 50) timeout("push_wait");
        bus.trans_req_i    = 2'b11;
        bus.trans_id_i[0]  = id;
        bus.trans_id_i[1]  = id;
        bus.trans_add_i[0] = a0;
        bus.trans_add_i[1] = a1;
        bus.trans_last_i   = last;
        bus.data_req_i     = 1'b1;
        bus.data_dat_i     = d;
        bus.data_strb_i    = s;
        b.add = a0; b.wdata = d[31:0];  b.be = s[3:0];
        if (lane_issues(s[3:0])) exp_beats0.push_back(b);
        b.add = a1; b.wdata = d[63:32]; b.be = s[7:4];
        if (lane_issues(s[7:4])) exp_beats1.push_back(b);
        if (last == 2'b11) exp_ids.push_back(id);
        @(posedge clk);
        #1;
        bus.trans_req_i = 2'b00;
        bus.data_req_i  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while ((exp_beats0.size() != 0 || exp_beats1.size() != 0 || exp_ids.size() != 0 ||
                bus.trans_r_req_o) && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 100) timeout(name);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tcdm_req"},   bus.tcdm_req_o,    2'b00);
        check({tag, "_tcdm_add"},   bus.tcdm_add_o,    64'h0);
        check({tag, "_tcdm_wdata"}, bus.tcdm_wdata_o,  64'h0);
        check({tag, "_tcdm_be"},    bus.tcdm_be_o,     8'h0);
        check({tag, "_tcdm_wen"},   bus.tcdm_wen_o,    2'b00);
        check({tag, "_r_req"},      bus.trans_r_req_o, 1'b0);
        check({tag, "_r_id"},       bus.trans_r_id_o,  6'h0);
        check({tag, "_trans_gnt"},  bus.trans_gnt_o,   2'b11);
        check({tag, "_data_gnt"},   bus.data_gnt_o,    1'b1);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{6'h05, 32'h0000_1000, 32'h0000_1004, 64'h11223344_55667788, 8'hFF,
                    32'h55667788, 32'h11223344, 4'hF, 4'hF};
        vecs[1] = '{6'h2A, 32'h0000_2000, 32'h0000_2004, 64'hDEADBEEF_CAFEF00D, 8'h3C,
                    32'hCAFEF00D, 32'hDEADBEEF, 4'hC, 4'h3};
        vecs[2] = '{6'h3F, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 64'hFFFFFFFF_00000000, 8'h81,
                    32'h00000000, 32'hFFFFFFFF, 4'h1, 4'h8};
        vecs[3] = '{6'h00, 32'h0000_0000, 32'h0000_0004, 64'h00000001_80000000, 8'h5A,
                    32'h80000000, 32'h00000001, 4'hA, 4'h5};
        vecs[4] = '{6'h11, 32'hABCD_0000, 32'h1234_0000, 64'h01234567_89ABCDEF, 8'hF1,
                    32'h89ABCDEF, 32'h01234567, 4'h1, 4'hF};

        rst_n = 1'b0;
        bus.trans_req_i   = 2'b00;
        bus.trans_id_i    = '0;
        bus.trans_add_i   = '0;
        bus.trans_last_i  = 2'b00;
        bus.data_req_i    = 1'b0;
        bus.data_dat_i    = '0;
        bus.data_strb_i   = '0;
        bus.trans_r_gnt_i = 1'b1;
        bus.tcdm_gnt_i    = 2'b11;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: single-beat bursts, issue one cycle after push, response one cycle after grant.
        for (int i = 0; i < 5; i++) begin
            push_beat(vecs[i].id, vecs[i].a0, vecs[i].a1, 2'b11, vecs[i].dat, vecs[i].strb);
            check($sformatf("vec%0d_tcdm_req", i), bus.tcdm_req_o, 2'b11);
            check($sformatf("vec%0d_add0", i),  bus.tcdm_add_o[0],   vecs[i].a0);
            check($sformatf("vec%0d_wd0", i),   bus.tcdm_wdata_o[0], vecs[i].e_wd0);
            check($sformatf("vec%0d_be0", i),   bus.tcdm_be_o[0],    vecs[i].e_be0);
            check($sformatf("vec%0d_add1", i),  bus.tcdm_add_o[1],   vecs[i].a1);
            check($sformatf("vec%0d_wd1", i),   bus.tcdm_wdata_o[1], vecs[i].e_wd1);
            check($sformatf("vec%0d_be1", i),   bus.tcdm_be_o[1],    vecs[i].e_be1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_r_req", i), bus.trans_r_req_o, 1'b1);
            check($sformatf("vec%0d_r_id", i),  bus.trans_r_id_o,  vecs[i].id);
            @(posedge clk);
            #1;
        end
        wait_idle("vec_drain");

        // 4-beat burst, lane 1 held off: lane 0 parks in L_DONE, response only after lane 1's 4th grant.
        bus.tcdm_gnt_i    = 2'b01;
        bus.trans_r_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++)
            push_beat(6'h03, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), (i == 3) ? 2'b11 : 2'b00,
                      {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)}, 8'hFF);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("burst4_lane0_parked", bus.tcdm_req_o, 2'b10);
        check("burst4_r_req_early", bus.trans_r_req_o, 1'b0);
        bus.tcdm_gnt_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) check($sformatf("burst4_r_req_wait%0d", i), bus.trans_r_req_o, 1'b0);
        end
        check("burst4_r_req", bus.trans_r_req_o, 1'b1);
        check("burst4_r_id",  bus.trans_r_id_o,  6'h03);
        bus.trans_r_gnt_i = 1'b1;
        wait_idle("burst4_drain");

        // Fill both lanes with TCDM stalled, then release.
        bus.tcdm_gnt_i = 2'b00;
        for (int i = 0; i < 4; i++)
            push_beat(6'h15, 32'h4000 + 32'(8 * i), 32'h4004 + 32'(8 * i), (i == 3) ? 2'b11 : 2'b00,
                      {32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)}, 8'hFF);
        check("fill_trans_gnt", bus.trans_gnt_o, 2'b00);
        check("fill_data_gnt",  bus.data_gnt_o,  1'b0);
        check("fill_tcdm_req",  bus.tcdm_req_o,  2'b11);
        bus.tcdm_gnt_i = 2'b11;
        @(posedge clk);
        #1;
        check("fill_trans_gnt_back", bus.trans_gnt_o, 2'b11);
        check("fill_data_gnt_back",  bus.data_gnt_o,  1'b1);
        wait_idle("fill_drain");

        // Response backpressure with the next burst queued behind it.
        bus.trans_r_gnt_i = 1'b0;
        push_beat(6'h07, 32'h5000, 32'h5004, 2'b11, 64'h0707_0707_7070_7070, 8'hFF);
        push_beat(6'h09, 32'h6000, 32'h6004, 2'b00, 64'h0909_0001_9090_0001, 8'hFF);
        push_beat(6'h09, 32'h6008, 32'h600C, 2'b11, 64'h0909_0002_9090_0002, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_tcdm_req", i), bus.tcdm_req_o,    2'b00);
            check($sformatf("bp%0d_r_req", i),    bus.trans_r_req_o, 1'b1);
            check($sformatf("bp%0d_r_id", i),     bus.trans_r_id_o,  6'h07);
        end
        bus.trans_r_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_tcdm_req", bus.tcdm_req_o,    2'b11);
        check("bp_released_add0",     bus.tcdm_add_o[0], 32'h6000);
        check("bp_released_r_req",    bus.trans_r_req_o, 1'b0);
        wait_idle("bp_drain");

        // Lane 1 has no byte enables on a last beat.
        push_beat(6'h0C, 32'h7000, 32'h7004, 2'b11, 64'h5555_5555_AAAA_AAAA, 8'h0F);
`ifdef AXI2MEM_WR_SKIP_NULL_STRB_EN
        check("nullstrb_tcdm_req", bus.tcdm_req_o, 2'b01);
`else
        check("nullstrb_tcdm_req", bus.tcdm_req_o, 2'b11);
        check("nullstrb_be1",      bus.tcdm_be_o[1], 4'h0);
`endif
        @(posedge clk);
        #1;
        check("nullstrb_r_req", bus.trans_r_req_o, 1'b1);
        check("nullstrb_r_id",  bus.trans_r_id_o,  6'h0C);
        wait_idle("nullstrb_drain");

        // Reset mid-burst drops buffered beats; a fresh burst then completes normally.
        bus.tcdm_gnt_i = 2'b00;
        push_beat(6'h21, 32'h8000, 32'h8004, 2'b00, 64'h2121_0001_1212_0001, 8'hFF);
        push_beat(6'h21, 32'h8008, 32'h800C, 2'b00, 64'h2121_0002_1212_0002, 8'hFF);
        rst_n = 1'b0;
        exp_beats0.delete();
        exp_beats1.delete();
        exp_ids.delete();
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.tcdm_gnt_i = 2'b11;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("midrst_no_tcdm_req", bus.tcdm_req_o,    2'b00);
            check("midrst_no_r_req",    bus.trans_r_req_o, 1'b0);
        end
        push_beat(6'h2E, 32'h9000, 32'h9004, 2'b11, 64'h2E2E_2E2E_E2E2_E2E2, 8'hFF);
        check("midrst_fresh_tcdm_req", bus.tcdm_req_o, 2'b11);
        wait_idle("midrst_drain");

        check("leftover_beats", 64'(exp_beats0.size() + exp_beats1.size()), 64'h0);
        check("leftover_resp",  64'(exp_ids.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
